// File: rtl/dpr_march_bist.sv
// March-style self-test for a true dual-port RAM: write via A, check via B,
// write complement via B, check via A; reports error count and first failure.
module dpr_march_bist #(
    parameter int                   ADDR_SIZE = 8,
    parameter int                   DATA_SIZE = 8,
    parameter int                   RAM_SIZE  = 1 << ADDR_SIZE,
    parameter logic [DATA_SIZE-1:0] SEED      = DATA_SIZE'(8'hA5)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDR_SIZE+1:0] err_count,
    output logic [ADDR_SIZE-1:0] first_err_addr,
    output logic                 first_err_port,
    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,
    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b,
    input  logic [DATA_SIZE-1:0] dout_b
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_RD_B,
        S_WR_B,
        S_RD_A,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_SIZE-1:0] LAST_ADDR = ADDR_SIZE'(RAM_SIZE - 1);

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   cnt_q, cnt_d, cnt_next;
    logic                   last;

    logic                   start_go;
    logic                   rd_issue;
    logic                   rd_port;
    logic [DATA_SIZE-1:0]   rd_exp;

    logic                   chk_vld_q;
    logic                   chk_port_q;
    logic [DATA_SIZE-1:0]   chk_exp_q;
    logic [ADDR_SIZE-1:0]   chk_addr_q;
    logic [DATA_SIZE-1:0]   rd_data;
    logic                   mismatch;

    logic [ADDR_SIZE+1:0]   err_cnt_q;
    logic [ADDR_SIZE-1:0]   first_addr_q;
    logic                   first_port_q;

    function automatic logic [DATA_SIZE-1:0] pat(input logic [ADDR_SIZE-1:0] k);
        return DATA_SIZE'(k) ^ SEED;
    endfunction

    assign last     = (cnt_q == LAST_ADDR);
    assign cnt_next = last ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        start_go = 1'b0;
        rd_issue = 1'b0;
        rd_port  = 1'b0;
        rd_exp   = '0;
        en_a     = 1'b0;
        we_a     = 1'b0;
        addr_a   = '0;
        din_a    = '0;
        en_b     = 1'b0;
        we_b     = 1'b0;
        addr_b   = '0;
        din_b    = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_WR_A;
                    cnt_d    = '0;
                    start_go = 1'b1;
                end
            end
            S_WR_A: begin
                en_a   = 1'b1;
                we_a   = 1'b1;
                addr_a = cnt_q;
                din_a  = pat(cnt_q);
                cnt_d  = cnt_next;
                if (last) state_d = S_RD_B;
            end
            S_RD_B: begin
                en_b     = 1'b1;
                addr_b   = cnt_q;
                rd_issue = 1'b1;
                rd_exp   = pat(cnt_q);
                cnt_d    = cnt_next;
                if (last) state_d = S_WR_B;
            end
            S_WR_B: begin
                en_b   = 1'b1;
                we_b   = 1'b1;
                addr_b = cnt_q;
                din_b  = ~pat(cnt_q);
                cnt_d  = cnt_next;
                if (last) state_d = S_RD_A;
            end
            S_RD_A: begin
                en_a     = 1'b1;
                addr_a   = cnt_q;
                rd_issue = 1'b1;
                rd_port  = 1'b1;
                rd_exp   = ~pat(cnt_q);
                cnt_d    = cnt_next;
                if (last) state_d = S_FLUSH;
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read data returns one cycle after the request, so compare against the staged expectation.
    assign rd_data  = chk_port_q ? dout_a : dout_b;
    assign mismatch = chk_vld_q && (rd_data != chk_exp_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            chk_vld_q    <= 1'b0;
            chk_port_q   <= 1'b0;
            chk_exp_q    <= '0;
            chk_addr_q   <= '0;
            err_cnt_q    <= '0;
            first_addr_q <= '0;
            first_port_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            chk_vld_q  <= rd_issue;
            chk_port_q <= rd_port;
            chk_exp_q  <= rd_exp;
            chk_addr_q <= cnt_q;
            if (start_go) begin
                err_cnt_q    <= '0;
                first_addr_q <= '0;
                first_port_q <= 1'b0;
            end else if (mismatch) begin
                if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + 1'b1;
                // Saturation never returns to zero, so zero marks "no error recorded yet".
                if (err_cnt_q == '0) begin
                    first_addr_q <= chk_addr_q;
                    first_port_q <= chk_port_q;
                end
            end
        end
    end

    assign busy           = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign pass           = done && (err_cnt_q == '0);
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_addr_q;
    assign first_err_port = first_port_q;

endmodule

// File: tb/tb_dpr_march_bist.sv
// Bench for dpr_march_bist: behavioural dual-port RAM with read-data fault injection,
// table-driven fault cases, randomized faults against an address-sweep model, corner sequences.
module tb_dpr_march_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start = 1'b0;
    logic start_s = 1'b0;

    // Default-sized instance
    logic       busy, done, pass, first_err_port;
    logic [9:0] err_count;
    logic [7:0] first_err_addr;
    logic       en_a, we_a, en_b, we_b;
    logic [7:0] addr_a, din_a, dout_a, addr_b, din_b, dout_b;

    // Small instance
    logic       busy_s, done_s, pass_s, first_err_port_s;
    logic [3:0] err_count_s;
    logic [1:0] first_err_addr_s;
    logic       en_a_s, we_a_s, en_b_s, we_b_s;
    logic [1:0] addr_a_s, addr_b_s;
    logic [3:0] din_a_s, dout_a_s, din_b_s, dout_b_s;

    dpr_march_bist dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr), .first_err_port(first_err_port),
        .en_a(en_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a), .dout_a(dout_a),
        .en_b(en_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b), .dout_b(dout_b)
    );

    dpr_march_bist #(.ADDR_SIZE(2), .DATA_SIZE(4), .SEED(4'h5)) dut_s (
        .clk(clk), .rst(rst), .start(start_s),
        .busy(busy_s), .done(done_s), .pass(pass_s),
        .err_count(err_count_s), .first_err_addr(first_err_addr_s), .first_err_port(first_err_port_s),
        .en_a(en_a_s), .we_a(we_a_s), .addr_a(addr_a_s), .din_a(din_a_s), .dout_a(dout_a_s),
        .en_b(en_b_s), .we_b(we_b_s), .addr_b(addr_b_s), .din_b(din_b_s), .dout_b(dout_b_s)
    );

    // RAM models: registered reads, faults applied on the read data path only
    logic [7:0] mem [256];
    logic [7:0] corr_a [256];
    logic [7:0] corr_b [256];
    logic [7:0] stuck_a = 8'h00, stuck_b = 8'h00;
    logic [7:0] ra_q = 8'h00, rb_q = 8'h00, ra_addr = 8'h00, rb_addr = 8'h00;
    logic [3:0] mem_s [4];
    logic [3:0] ra_s_q = 4'h0, rb_s_q = 4'h0;

    always @(posedge clk) begin
        if (en_a) begin
            if (we_a) mem[addr_a] <= din_a;
            else begin ra_q <= mem[addr_a]; ra_addr <= addr_a; end
        end
        if (en_b) begin
            if (we_b) mem[addr_b] <= din_b;
            else begin rb_q <= mem[addr_b]; rb_addr <= addr_b; end
        end
        if (en_a_s) begin
            if (we_a_s) mem_s[addr_a_s] <= din_a_s;
            else ra_s_q <= mem_s[addr_a_s];
        end
        if (en_b_s) begin
            if (we_b_s) mem_s[addr_b_s] <= din_b_s;
            else rb_s_q <= mem_s[addr_b_s];
        end
    end

    assign dout_a   = (ra_q ^ corr_a[ra_addr]) | stuck_a;
    assign dout_b   = (rb_q ^ corr_b[rb_addr]) | stuck_b;
    assign dout_a_s = ra_s_q;
    assign dout_b_s = rb_s_q;

    // Monitors: port-A write sequence, port overlap, small-instance port-B write data
    int         wr_a_seen = 0, wr_a_bad = 0, overlap = 0;
    logic [7:0] wr_a_prev = 8'hFF;
    logic [3:0] din_b_s_q[$];

    always @(negedge clk) begin
        if (en_a && we_a) begin
            wr_a_seen++;
            if (addr_a != wr_a_prev + 8'd1 || din_a != (addr_a ^ 8'hA5) || en_b) wr_a_bad++;
            wr_a_prev = addr_a;
        end
        if (en_a && en_b) overlap++;
        if (en_b_s && we_b_s) din_b_s_q.push_back(din_b_s);
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 256; i++) begin
            corr_a[i] = 8'h00;
            corr_b[i] = 8'h00;
        end
        stuck_a = 8'h00;
        stuck_b = 8'h00;
    endtask

    // Start the default instance and count edges until done (bounded); optional start re-pulses.
    task automatic run_dut(input int p1, input int p2, output int lat);
        int cyc;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (!done && cyc < 2000) begin
            if (cyc == p1 || cyc == p2) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        lat = cyc;
    endtask

    // Reference: sweep RD_B then RD_A in address order, applying the fault definition to each read.
    function automatic void model(output int cnt, output int faddr, output int fport);
        logic [7:0] p, got;
        bit found;
        cnt = 0; faddr = 0; fport = 0; found = 0;
        for (int k = 0; k < 256; k++) begin
            p   = 8'(k) ^ 8'hA5;
            got = (p ^ corr_b[k]) | stuck_b;
            if (got != p) begin
                if (!found) begin faddr = k; fport = 0; found = 1; end
                cnt++;
            end
        end
        for (int k = 0; k < 256; k++) begin
            p   = ~(8'(k) ^ 8'hA5);
            got = (p ^ corr_a[k]) | stuck_a;
            if (got != p) begin
                if (!found) begin faddr = k; fport = 1; found = 1; end
                cnt++;
            end
        end
        if (cnt > 1023) cnt = 1023;
    endfunction

    typedef struct {
        logic [7:0] stuck_a, stuck_b, a_addr, a_mask, b_addr, b_mask;
        int exp_cnt, exp_addr, exp_port, exp_pass;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int lat, m_cnt, m_addr, m_port, seen0, bad0, n;
        string tag;

        vecs[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,   0, 8'h00, 0, 1};
        vecs[1] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 128, 8'h01, 0, 0};
        vecs[2] = '{8'h00, 8'h00, 8'h3C, 8'h01, 8'h00, 8'h00,   1, 8'h3C, 1, 0};
        vecs[3] = '{8'h00, 8'h00, 8'h10, 8'h03, 8'hFF, 8'h80,   2, 8'hFF, 0, 0};
        vecs[4] = '{8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 128, 8'h80, 0, 0};
        vecs[5] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 128, 8'h02, 1, 0};

        clear_faults();
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset pass", pass, 0);
        chk("reset en_a|en_b|we_a|we_b", {en_a, en_b, we_a, we_b}, 0);
        chk("reset addr/din", {addr_a, din_a, addr_b, din_b}, 0);
        chk("reset err_count", err_count, 0);
        chk("reset first_err", {first_err_addr, first_err_port}, 0);
        rst = 1'b0;

        // Table-driven fault cases
        for (int v = 0; v < 6; v++) begin
            clear_faults();
            stuck_a = vecs[v].stuck_a;
            stuck_b = vecs[v].stuck_b;
            corr_a[vecs[v].a_addr] = vecs[v].a_mask;
            corr_b[vecs[v].b_addr] = vecs[v].b_mask;
            seen0 = wr_a_seen;
            bad0  = wr_a_bad;
            run_dut(-1, -1, lat);
            tag = $sformatf("vec%0d", v);
            chk({tag, " done latency"}, lat, 1025);
            chk({tag, " busy"}, busy, 0);
            chk({tag, " err_count"}, err_count, vecs[v].exp_cnt);
            chk({tag, " first_err_addr"}, first_err_addr, vecs[v].exp_addr);
            chk({tag, " first_err_port"}, first_err_port, vecs[v].exp_port);
            chk({tag, " pass"}, pass, vecs[v].exp_pass);
            if (v == 0) begin
                chk("vec0 port-A writes", wr_a_seen - seen0, 256);
                chk("vec0 bad port-A writes", wr_a_bad - bad0, 0);
            end
        end

        // Randomized faults against the reference model
        for (int r = 0; r < 4; r++) begin
            clear_faults();
            if ($urandom_range(0, 2) == 0) stuck_b = 8'h01 << $urandom_range(0, 7);
            if ($urandom_range(0, 2) == 0) stuck_a = 8'h01 << $urandom_range(0, 7);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) corr_b[$urandom_range(0, 255)] = 8'($urandom);
            n = $urandom_range(0, 5);
            for (int i = 0; i < n; i++) corr_a[$urandom_range(0, 255)] = 8'($urandom);
            model(m_cnt, m_addr, m_port);
            run_dut(-1, -1, lat);
            tag = $sformatf("rand%0d", r);
            chk({tag, " done latency"}, lat, 1025);
            chk({tag, " err_count"}, err_count, m_cnt);
            chk({tag, " first_err_addr"}, first_err_addr, m_addr);
            chk({tag, " first_err_port"}, first_err_port, m_port);
            chk({tag, " pass"}, pass, (m_cnt == 0));
        end

        // Reset mid-test while errors are accumulating
        clear_faults();
        stuck_b = 8'h01;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("midrst errors before rst", (err_count != 0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst busy", busy, 0);
        chk("midrst done", done, 0);
        chk("midrst en_a|en_b", {en_a, en_b}, 0);
        chk("midrst err_count", err_count, 0);
        rst = 1'b0;
        clear_faults();
        run_dut(-1, -1, lat);
        chk("post-rst done latency", lat, 1025);
        chk("post-rst pass", pass, 1);

        // start re-pulsed while busy is ignored; start in DONE restarts
        run_dut(10, 700, lat);
        chk("busy-start done latency", lat, 1025);
        chk("busy-start pass", pass, 1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("restart done dropped", done, 0);
        chk("restart busy", busy, 1);
        lat = 0;
        while (!done && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("restart done latency", lat, 1025);
        chk("port overlap cycles", overlap, 0);

        // Small instance: ADDR_SIZE=2, DATA_SIZE=4, SEED=5
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        lat = 0;
        while (!done_s && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("small done latency", lat, 17);
        chk("small pass", pass_s, 1);
        chk("small err_count", err_count_s, 0);
        chk("small WR_B writes", din_b_s_q.size(), 4);
        if (din_b_s_q.size() == 4) begin
            chk("small din_b[0]", din_b_s_q[0], 4'hA);
            chk("small din_b[1]", din_b_s_q[1], 4'hB);
            chk("small din_b[2]", din_b_s_q[2], 4'h8);
            chk("small din_b[3]", din_b_s_q[3], 4'h9);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
